// File: rtl/stream_pkg.sv
// Shared types and helpers for the valid/ready value-stream endpoints.
//   sink_state_t : sink checker FSM states
//   stall_mode_t : backpressure pattern selector
//   lfsr_step    : one shift of the 16-bit Fibonacci LFSR
//   stall_ready  : ready level for a given pattern and per-cycle sources
package stream_pkg;

  localparam int unsigned LFSR_WIDTH = 16;

  // Right-shifting Fibonacci taps for x^16 + x^14 + x^13 + x^11 + 1
  // (state bits 0, 2, 3 and 5 feed the new MSB).
  localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS         = 16'h002D;
  localparam logic [LFSR_WIDTH-1:0] LFSR_DEFAULT_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sink_state_t;

  typedef enum logic [1:0] {
    STALL_NONE      = 2'd0,
    STALL_RANDOM    = 2'd1,
    STALL_ALTERNATE = 2'd2,
    STALL_ALWAYS    = 2'd3
  } stall_mode_t;

  // One LFSR shift: feedback enters at the MSB, state moves toward bit 0.
  function automatic logic [LFSR_WIDTH-1:0] lfsr_step(input logic [LFSR_WIDTH-1:0] s);
    return {^(s & LFSR_TAPS), s[LFSR_WIDTH-1:1]};
  endfunction

  // Ready level while running, given the random bit and alternate phase.
  function automatic logic stall_ready(input stall_mode_t mode,
                                       input logic        rand_bit,
                                       input logic        phase);
    logic rdy;
    rdy = 1'b0;
    case (mode)
      STALL_NONE:      rdy = 1'b1;
      STALL_RANDOM:    rdy = rand_bit;
      STALL_ALTERNATE: rdy = ~phase;
      STALL_ALWAYS:    rdy = 1'b0;
      default:         rdy = 1'b0;
    endcase
    return rdy;
  endfunction

endpackage

// File: rtl/stream_lfsr.sv
// 16-bit Fibonacci LFSR used for pseudo-random stream backpressure/traffic.
// Ports:
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset (state cleared to 0)
//   i_load   : load i_seed this cycle (takes priority over i_en)
//   i_seed   : seed value, must be nonzero for a useful sequence
//   i_en     : advance one step this cycle
//   o_state  : current LFSR state
module stream_lfsr
  import stream_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_load,
  input  logic [LFSR_WIDTH-1:0] i_seed,
  input  logic                  i_en,
  output logic [LFSR_WIDTH-1:0] o_state
);

  logic [LFSR_WIDTH-1:0] r_state;

  // Shift register: load wins over step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= '0;
    end else if (i_load) begin
      r_state <= i_seed;
    end else if (i_en) begin
      r_state <= lfsr_step(r_state);
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/stream_sink_checker.sv
// Slave-side terminating endpoint of the valid/ready value stream.
// Applies a programmable backpressure pattern on ready, checks accepted
// values against an incrementing sequence, and reports counts/completion.
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset
//   value, valid   : stream payload and valid (in)
//   ready          : stream ready (out, registered)
//   start          : run request, sampled only in IDLE
//   length, first  : beats in the run and expected first value (latched on start)
//   stall_mode     : backpressure pattern (latched on start)
//   busy, done     : running flag and one-cycle completion pulse
//   error, error_count, beat_count, last_bad : run results, held until next start
module stream_sink_checker
  import stream_pkg::*;
#(
  parameter int unsigned           BITS       = 8,
  parameter int unsigned           COUNT_BITS = 16,
  parameter logic [LFSR_WIDTH-1:0] LFSR_SEED  = LFSR_DEFAULT_SEED
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [BITS-1:0]       value,
  input  logic                  valid,
  output logic                  ready,
  input  logic                  start,
  input  logic [COUNT_BITS-1:0] length,
  input  logic [BITS-1:0]       first,
  input  logic [1:0]            stall_mode,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [COUNT_BITS-1:0] error_count,
  output logic [COUNT_BITS-1:0] beat_count,
  output logic [BITS-1:0]       last_bad
);

  sink_state_t           r_state;
  stall_mode_t           r_mode;
  logic [COUNT_BITS-1:0] r_length;
  logic [COUNT_BITS-1:0] r_beat_count;
  logic [COUNT_BITS-1:0] r_error_count;
  logic [BITS-1:0]       r_expected;
  logic [BITS-1:0]       r_last_bad;
  logic                  r_phase;
  logic                  r_ready;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_error;

  logic [LFSR_WIDTH-1:0] w_lfsr;
  logic [LFSR_WIDTH-1:0] w_lfsr_next;
  logic                  w_lfsr_unused;
  logic                  w_start_ok;
  logic                  w_handshake;
  logic                  w_last_beat;
  logic [COUNT_BITS-1:0] w_beat_inc;

  // Backpressure source: seeded on an accepted start, steps every RUN cycle.
  stream_lfsr u_lfsr (
    .clk     (clock),
    .rst_n   (reset_n),
    .i_load  (w_start_ok),
    .i_seed  (LFSR_SEED),
    .i_en    (r_state == RUN),
    .o_state (w_lfsr)
  );

  // ready is registered, so the next cycle's level is built from the
  // LFSR value it will hold after this cycle's step.
  assign w_lfsr_next   = lfsr_step(w_lfsr);
  assign w_lfsr_unused = ^w_lfsr_next[LFSR_WIDTH-1:1];

  assign w_start_ok  = (r_state == IDLE) && start;
  assign w_handshake = (r_state == RUN) && valid && r_ready;
  assign w_beat_inc  = COUNT_BITS'(r_beat_count + 1'b1);
  assign w_last_beat = w_handshake && (w_beat_inc == r_length);

  // Run control, backpressure and result tracking.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_mode        <= STALL_NONE;
      r_length      <= '0;
      r_beat_count  <= '0;
      r_error_count <= '0;
      r_expected    <= '0;
      r_last_bad    <= '0;
      r_phase       <= 1'b0;
      r_ready       <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_length      <= length;
            r_expected    <= first;
            r_mode        <= stall_mode_t'(stall_mode);
            r_phase       <= 1'b0;
            r_beat_count  <= '0;
            r_error_count <= '0;
            r_error       <= 1'b0;
            r_last_bad    <= '0;
            if (length != '0) begin
              r_state <= RUN;
              r_busy  <= 1'b1;
              r_ready <= stall_ready(stall_mode_t'(stall_mode), LFSR_SEED[0], 1'b0);
            end else begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end
          end
        end

        RUN: begin
          r_phase <= ~r_phase;
          if (w_handshake) begin
            r_beat_count <= w_beat_inc;
            // Comparison is positional: expected advances even on a mismatch.
            r_expected   <= BITS'(r_expected + 1'b1);
            if (value != r_expected) begin
              r_error    <= 1'b1;
              r_last_bad <= value;
              if (r_error_count != '1) begin
                r_error_count <= COUNT_BITS'(r_error_count + 1'b1);
              end
            end
          end
          if (w_last_beat) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_ready <= 1'b0;
          end else begin
            r_ready <= stall_ready(r_mode, w_lfsr_next[0], ~r_phase);
          end
        end

        DONE: begin
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign ready       = r_ready;
  assign busy        = r_busy;
  assign done        = r_done;
  assign error       = r_error;
  assign error_count = r_error_count;
  assign beat_count  = r_beat_count;
  assign last_bad    = r_last_bad;

endmodule

// File: tb/tb_stream_sink_checker.sv
// Directed self-checking bench for stream_sink_checker.
module tb_stream_sink_checker;

  localparam int unsigned BITS = 8;
  localparam int unsigned CB   = 16;

  logic            clock = 1'b0;
  logic            reset_n;
  logic [BITS-1:0] value;
  logic            valid;
  logic            ready;
  logic            start;
  logic [CB-1:0]   length;
  logic [BITS-1:0] first;
  logic [1:0]      stall_mode;
  logic            busy;
  logic            done;
  logic            error;
  logic [CB-1:0]   error_count;
  logic [CB-1:0]   beat_count;
  logic [BITS-1:0] last_bad;

  int checks = 0;
  int errors = 0;

  stream_sink_checker #(.BITS(BITS), .COUNT_BITS(CB), .LFSR_SEED(16'hACE1)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .value       (value),
    .valid       (valid),
    .ready       (ready),
    .start       (start),
    .length      (length),
    .first       (first),
    .stall_mode  (stall_mode),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .error_count (error_count),
    .beat_count  (beat_count),
    .last_bad    (last_bad)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; sampling and driving happen 1ns after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic start_run(input logic [BITS-1:0] f, input logic [CB-1:0] len, input logic [1:0] mode);
    first      = f;
    length     = len;
    stall_mode = mode;
    start      = 1'b1;
    step();
    start      = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [BITS-1:0] t2_vals [4];
    logic [15:0]     lf;
    logic            exp_r;
    int              hs;

    t2_vals    = '{8'h10, 8'h11, 8'hFF, 8'h13};
    reset_n    = 1'b0;
    value      = '0;
    valid      = 1'b0;
    start      = 1'b0;
    length     = '0;
    first      = '0;
    stall_mode = 2'd0;
    step();
    step();

    // Reset state
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_done",  32'(done),  32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_beats", 32'(beat_count), 32'd0);
    check("rst_ecnt",  32'(error_count), 32'd0);
    check("rst_lbad",  32'(last_bad), 32'd0);
    reset_n = 1'b1;
    step();

    // 1: mode 0, clean sequence 10..13
    start_run(8'h10, 16'd4, 2'd0);
    check("t1_busy", 32'(busy), 32'd1);
    valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      value = BITS'(8'h10 + i);
      check("t1_ready", 32'(ready), 32'd1);
      check("t1_done_low", 32'(done), 32'd0);
      step();
    end
    valid = 1'b0;
    check("t1_done",  32'(done),  32'd1);
    check("t1_busy_low", 32'(busy), 32'd0);
    check("t1_ready_low", 32'(ready), 32'd0);
    check("t1_beats", 32'(beat_count), 32'd4);
    check("t1_error", 32'(error), 32'd0);
    step();
    check("t1_done_once", 32'(done), 32'd0);
    check("t1_beats_hold", 32'(beat_count), 32'd4);

    // 2: mode 0, third beat corrupted
    start_run(8'h10, 16'd4, 2'd0);
    valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t2_ready", 32'(ready), 32'd1);
      check("t2_error_latency", 32'(error), 32'(i == 3));
      value = t2_vals[i];
      step();
    end
    valid = 1'b0;
    check("t2_done",  32'(done), 32'd1);
    check("t2_error", 32'(error), 32'd1);
    check("t2_ecnt",  32'(error_count), 32'd1);
    check("t2_lbad",  32'(last_bad), 32'hFF);
    check("t2_beats", 32'(beat_count), 32'd4);
    step();
    check("t2_error_hold", 32'(error), 32'd1);

    // 3: mode 0, expected value wraps FE,FF,00,01
    start_run(8'hFE, 16'd4, 2'd0);
    check("t3_error_clr", 32'(error), 32'd0);
    check("t3_ecnt_clr",  32'(error_count), 32'd0);
    check("t3_lbad_clr",  32'(last_bad), 32'd0);
    valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      value = BITS'(8'hFE + i);
      step();
    end
    valid = 1'b0;
    check("t3_done",  32'(done), 32'd1);
    check("t3_error", 32'(error), 32'd0);
    check("t3_beats", 32'(beat_count), 32'd4);
    step();

    // 4: mode 2, alternate ready 1,0,1,0,1 with valid held high
    start_run(8'h40, 16'd3, 2'd2);
    valid = 1'b1;
    hs = 0;
    for (int i = 0; i < 5; i++) begin
      exp_r = (i % 2 == 0);
      check("t4_ready", 32'(ready), 32'(exp_r));
      value = BITS'(8'h40 + hs);
      step();
      if (exp_r) hs++;
    end
    valid = 1'b0;
    check("t4_done",  32'(done), 32'd1);
    check("t4_beats", 32'(beat_count), 32'd3);
    check("t4_error", 32'(error), 32'd0);
    step();

    // 4r: mode 1, ready follows the LFSR bit 0 from seed ACE1
    lf = 16'hACE1;
    hs = 0;
    start_run(8'h30, 16'd6, 2'd1);
    valid = 1'b1;
    for (int c = 0; c < 64 && hs < 6; c++) begin
      exp_r = lf[0];
      check("t4r_ready", 32'(ready), 32'(exp_r));
      value = BITS'(8'h30 + hs);
      step();
      if (exp_r) hs++;
      lf = {lf[0] ^ lf[2] ^ lf[3] ^ lf[5], lf[15:1]};
    end
    valid = 1'b0;
    check("t4r_done",  32'(done), 32'd1);
    check("t4r_beats", 32'(beat_count), 32'd6);
    check("t4r_error", 32'(error), 32'd0);
    step();

    // 6a: zero-length run goes straight to DONE and clears counters
    start_run(8'h99, 16'd0, 2'd0);
    check("t6_done",  32'(done), 32'd1);
    check("t6_busy",  32'(busy), 32'd0);
    check("t6_ready", 32'(ready), 32'd0);
    check("t6_beats", 32'(beat_count), 32'd0);
    step();
    check("t6_done_once", 32'(done), 32'd0);
    check("t6_ready_idle", 32'(ready), 32'd0);

    // 6b: start pulsed mid-run is ignored
    start_run(8'h20, 16'd3, 2'd0);
    valid = 1'b1;
    value = 8'h20;
    step();
    start      = 1'b1;
    first      = 8'h80;
    length     = 16'd1;
    stall_mode = 2'd3;
    value      = 8'h21;
    check("t6b_ready1", 32'(ready), 32'd1);
    step();
    start = 1'b0;
    value = 8'h22;
    check("t6b_ready2", 32'(ready), 32'd1);
    check("t6b_busy",   32'(busy), 32'd1);
    step();
    valid = 1'b0;
    check("t6b_done",  32'(done), 32'd1);
    check("t6b_beats", 32'(beat_count), 32'd3);
    check("t6b_error", 32'(error), 32'd0);
    step();

    // 5: mode 3 never ready, then reset mid-run
    start_run(8'h00, 16'd2, 2'd3);
    valid = 1'b1;
    value = 8'h00;
    for (int i = 0; i < 10; i++) begin
      check("t5_ready", 32'(ready), 32'd0);
      step();
    end
    check("t5_beats", 32'(beat_count), 32'd0);
    check("t5_busy",  32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("t5_rst_ready", 32'(ready), 32'd0);
    check("t5_rst_busy",  32'(busy), 32'd0);
    check("t5_rst_done",  32'(done), 32'd0);
    check("t5_rst_beats", 32'(beat_count), 32'd0);
    check("t5_rst_ecnt",  32'(error_count), 32'd0);
    valid = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    check("t5_idle_busy", 32'(busy), 32'd0);
    check("t5_idle_done", 32'(done), 32'd0);
    start_run(8'h55, 16'd1, 2'd0);
    check("t5_post_ready", 32'(ready), 32'd1);
    valid = 1'b1;
    value = 8'h55;
    step();
    valid = 1'b0;
    check("t5_post_done",  32'(done), 32'd1);
    check("t5_post_beats", 32'(beat_count), 32'd1);
    check("t5_post_error", 32'(error), 32'd0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
